// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared widths and slot type for the instruction fetch queue
//
// Purpose : constants and the line-slot record used by ifq and ifq_line_mem.
// Contents: INSTR_W, LINE_W, WORDS_PER_LINE, OFFS_W, slot_t {line, base_pc}.
package ifq_pkg;

  localparam int INSTR_W        = 32;
  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = LINE_W / INSTR_W;
  localparam int OFFS_W         = $clog2(WORDS_PER_LINE);

  typedef struct packed {
    logic [LINE_W-1:0]  line;
    logic [INSTR_W-1:0] base_pc;
  } slot_t;

endpackage

// File: rtl/ifq_line_mem.sv
// rtl/ifq_line_mem.sv - line slot storage with one write port and a word-select read port
//
// Purpose : DEPTH x (line + base PC) register array. Contents are never reset.
// Ports   : clk        in   clock
//           wr_en      in   write slot wr_addr with wr_data
//           wr_addr    in   slot index to write
//           wr_data    in   slot record (line, base_pc)
//           rd_addr    in   slot index to read
//           rd_word    in   word within the read slot
//           rd_instr   out  selected 32-bit word
//           rd_base_pc out  base PC of the read slot
module ifq_line_mem
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  slot_t              wr_data,
  input  logic [AW-1:0]      rd_addr,
  input  logic [OFFS_W-1:0]  rd_word,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [INSTR_W-1:0] rd_base_pc
);

  slot_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  slot_t w_rd_slot;

  always_comb begin
    w_rd_slot  = r_mem[rd_addr];
    rd_instr   = w_rd_slot.line[rd_word*INSTR_W +: INSTR_W];
    rd_base_pc = w_rd_slot.base_pc;
  end

endmodule

// File: rtl/ifq.sv
// rtl/ifq.sv - instruction fetch queue between i_cache and decode
//
// Purpose : fetches 128-bit lines sequentially from the i_cache, buffers
//           DEPTH_LINES of them and hands out one 32-bit instruction per pop.
//           A redirect flushes the queue and restarts fetch at the target.
// Ports   : clk, rst (sync, active-high)
//           jmp_br_valid/jmp_br_addr  in   redirect request and target
//           pc_out/cache_rd_en/cache_abort  out  i_cache request side
//           cache_dout/cache_dout_valid     in   i_cache same-cycle response
//           dout/dout_pc/dout_valid   out  head instruction and its address
//           dout_ready                in   consumer pop
//           full/empty                out  line occupancy status
module ifq
  import ifq_pkg::*;
#(
  parameter int          DEPTH_LINES = 4,
  parameter logic [31:0] PC_RESET    = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jmp_br_valid,
  input  logic [31:0]         jmp_br_addr,
  output logic [31:0]         pc_out,
  output logic                cache_rd_en,
  output logic                cache_abort,
  input  logic [LINE_W-1:0]   cache_dout,
  input  logic                cache_dout_valid,
  output logic [INSTR_W-1:0]  dout,
  output logic [31:0]         dout_pc,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                full,
  output logic                empty
);

  localparam int AW = $clog2(DEPTH_LINES);
  localparam int RW = AW + OFFS_W;  // rd_ptr = {wrap, slot, word}

  localparam logic [AW:0] WR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [RW:0] RD_ONE = {{RW{1'b0}}, 1'b1};

  logic [AW:0]  r_wr_ptr;
  logic [RW:0]  r_rd_ptr;
  logic [31:0]  r_pc;

  logic               w_empty;
  logic               w_full;
  logic               w_rd_en;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_pc_line;
  logic [INSTR_W-1:0] w_rd_instr;
  logic [31:0]        w_rd_base_pc;
  slot_t              w_wr_slot;
  logic               w_unused_addr_lsb;

  // Byte offset bits of the target are don't-care: targets are word-aligned.
  assign w_unused_addr_lsb = ^jmp_br_addr[1:0];

  // Occupancy compares whole lines only; the word index never matters here.
  assign w_empty = (r_rd_ptr[RW:OFFS_W] == r_wr_ptr);
  assign w_full  = (r_rd_ptr[RW-1:OFFS_W] == r_wr_ptr[AW-1:0]) &&
                   (r_rd_ptr[RW] != r_wr_ptr[AW]);

  assign w_pc_line = {r_pc[31:4], 4'h0};
  assign w_rd_en   = !w_full && !jmp_br_valid;
  assign w_push    = w_rd_en && cache_dout_valid;
  assign w_pop     = !w_empty && dout_ready && !jmp_br_valid;

  assign w_wr_slot.line    = cache_dout;
  assign w_wr_slot.base_pc = w_pc_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= PC_RESET;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (jmp_br_valid) begin
      // Restart at slot 0; the word offset skips the target line's lower words.
      r_pc     <= {jmp_br_addr[31:4], 4'h0};
      r_wr_ptr <= '0;
      r_rd_ptr <= {{(AW+1){1'b0}}, jmp_br_addr[3:2]};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + WR_ONE;
        r_pc     <= w_pc_line + 32'd16;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + RD_ONE;
      end
    end
  end

  ifq_line_mem #(
    .DEPTH (DEPTH_LINES),
    .AW    (AW)
  ) u_line_mem (
    .clk        (clk),
    .wr_en      (w_push && !rst),
    .wr_addr    (r_wr_ptr[AW-1:0]),
    .wr_data    (w_wr_slot),
    .rd_addr    (r_rd_ptr[RW-1:OFFS_W]),
    .rd_word    (r_rd_ptr[OFFS_W-1:0]),
    .rd_instr   (w_rd_instr),
    .rd_base_pc (w_rd_base_pc)
  );

  assign pc_out      = w_pc_line;
  assign cache_rd_en = w_rd_en;
  assign cache_abort = jmp_br_valid;
  assign full        = w_full;
  assign empty       = w_empty;
  assign dout_valid  = !w_empty;
  assign dout        = w_empty ? '0 : w_rd_instr;
  assign dout_pc     = w_empty ? 32'h0 :
                       w_rd_base_pc + {{(32-OFFS_W-2){1'b0}}, r_rd_ptr[OFFS_W-1:0], 2'b00};

endmodule

// File: tb/tb_ifq.sv
// tb/tb_ifq.sv - self-checking scoreboard bench for ifq
module tb_ifq;

  localparam int          DEPTH = 4;
  localparam logic [31:0] PCR   = 32'h0000_0000;

  logic         clk;
  logic         rst;
  logic         jmp_br_valid;
  logic [31:0]  jmp_br_addr;
  logic [31:0]  pc_out;
  logic         cache_rd_en;
  logic         cache_abort;
  logic [127:0] cache_dout;
  logic         cache_dout_valid;
  logic [31:0]  dout;
  logic [31:0]  dout_pc;
  logic         dout_valid;
  logic         dout_ready;
  logic         full;
  logic         empty;

  ifq #(.DEPTH_LINES(DEPTH), .PC_RESET(PCR)) dut (
    .clk              (clk),
    .rst              (rst),
    .jmp_br_valid     (jmp_br_valid),
    .jmp_br_addr      (jmp_br_addr),
    .pc_out           (pc_out),
    .cache_rd_en      (cache_rd_en),
    .cache_abort      (cache_abort),
    .cache_dout       (cache_dout),
    .cache_dout_valid (cache_dout_valid),
    .dout             (dout),
    .dout_pc          (dout_pc),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready),
    .full             (full),
    .empty            (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: base PCs of lines the model expects to be queued.
  logic [31:0] sb_lines[$];
  logic [31:0] m_pc;
  int          m_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] p);
    return {instr_of(p + 32'd12), instr_of(p + 32'd8), instr_of(p + 32'd4), instr_of(p)};
  endfunction

  // Drives one cycle (called just after a rising edge), checks outputs at the
  // falling edge against the model, then advances the model to the next edge.
  task automatic cycle(input logic rs, input logic jb, input logic [31:0] ja,
                       input logic cv, input logic dr);
    logic        m_empty, m_full, m_rd_en, do_pop, do_push;
    logic [31:0] m_pc_line, e_dout, e_dpc, hp;
    rst              = rs;
    jmp_br_valid     = jb;
    jmp_br_addr      = ja;
    cache_dout_valid = cv;
    dout_ready       = dr;
    m_pc_line        = {m_pc[31:4], 4'h0};
    cache_dout       = line_of(m_pc_line);
    m_empty = (sb_lines.size() == 0);
    m_full  = (sb_lines.size() == DEPTH);
    m_rd_en = !m_full && !jb;
    if (m_empty) begin
      e_dout = 32'h0;
      e_dpc  = 32'h0;
    end else begin
      hp     = sb_lines[0] + 32'(m_word * 4);
      e_dout = instr_of(hp);
      e_dpc  = hp;
    end
    @(negedge clk);
    check("pc_out",      pc_out,             m_pc_line);
    check("cache_rd_en", {31'b0, cache_rd_en}, {31'b0, m_rd_en});
    check("cache_abort", {31'b0, cache_abort}, {31'b0, jb});
    check("full",        {31'b0, full},       {31'b0, m_full});
    check("empty",       {31'b0, empty},      {31'b0, m_empty});
    check("dout_valid",  {31'b0, dout_valid}, {31'b0, !m_empty});
    check("dout",        dout,               e_dout);
    check("dout_pc",     dout_pc,            e_dpc);
    if (rs) begin
      m_pc   = PCR;
      m_word = 0;
      sb_lines.delete();
    end else if (jb) begin
      m_pc   = {ja[31:4], 4'h0};
      m_word = int'(ja[3:2]);
      sb_lines.delete();
    end else begin
      do_pop  = !m_empty && dr;
      do_push = m_rd_en && cv;
      if (do_pop) begin
        if (m_word == 3) begin
          m_word = 0;
          void'(sb_lines.pop_front());
        end else begin
          m_word++;
        end
      end
      if (do_push) begin
        sb_lines.push_back(m_pc_line);
        m_pc = m_pc_line + 32'd16;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b1;
    jmp_br_valid     = 1'b0;
    jmp_br_addr      = 32'h0;
    cache_dout       = '0;
    cache_dout_valid = 1'b0;
    dout_ready       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_pc   = PCR;
    m_word = 0;

    // Reset state, then idle with no cache response: nothing queued.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    // Fill to full with consumer stalled; pc_out holds at 0x40.
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    // Drain continuously while the cache keeps responding.
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    // Redirect to 0x128 into a populated queue.
    cycle(1'b0, 1'b1, 32'h0000_0128, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    // Redirect with pop and cache response asserted together.
    cycle(1'b0, 1'b1, 32'h0000_0F3C, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    // Reset mid-stream with a valid head being popped.
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    // Redirect while full, including a wrap near the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFE8, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r_rs, r_jb, r_cv, r_dr;
      logic [31:0] r_ja;
      r_rs = ($urandom_range(0, 99) == 0);
      r_jb = ($urandom_range(0, 24) == 0);
      r_cv = ($urandom_range(0, 3) != 0);
      r_dr = ($urandom_range(0, 2) != 0);
      r_ja = {$urandom(), 2'b00} & 32'h0000_FFFC;
      cycle(r_rs, r_jb, r_ja, r_cv, r_dr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
